// File: rtl/spike_readout_if.sv
//==============================================================================
// Module      : spike_readout_if
// Description : Spike-line, window-control and result handshake bundle for
//               spike_readout. SPIKE_READOUT_MIN_COUNT_EN adds min_count and
//               no_decision.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface spike_readout_if #(
    parameter int N_OUT    = 2,
    parameter int CNT_W    = 8,
    parameter int WIN_W    = 16,
    parameter int WINNER_W = 1
);
    logic [N_OUT-1:0]       spike_in;
    logic                   start;
    logic [WIN_W-1:0]       win_len;
    logic                   result_ready;
    logic                   busy;
    logic                   result_valid;
    logic [N_OUT*CNT_W-1:0] count_out;
    logic [WINNER_W-1:0]    winner;
    logic [N_OUT-1:0]       sat;
`ifdef SPIKE_READOUT_MIN_COUNT_EN
    logic [CNT_W-1:0]       min_count;
    logic                   no_decision;

    modport master (
        output spike_in, start, win_len, result_ready, min_count,
        input  busy, result_valid, count_out, winner, sat, no_decision
    );
    modport slave (
        input  spike_in, start, win_len, result_ready, min_count,
        output busy, result_valid, count_out, winner, sat, no_decision
    );
`else
    modport master (
        output spike_in, start, win_len, result_ready,
        input  busy, result_valid, count_out, winner, sat
    );
    modport slave (
        input  spike_in, start, win_len, result_ready,
        output busy, result_valid, count_out, winner, sat
    );
`endif
endinterface

`default_nettype wire

// File: rtl/spike_readout.sv
//==============================================================================
// Module      : spike_readout
// Description : Counts spikes per output neuron over a programmable window,
//               then reports saturating counts and an argmax winner under a
//               valid/ready handshake. Optional macro SPIKE_READOUT_MIN_COUNT_EN
//               flags windows whose winning count is below min_count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spike_readout #(
    parameter int N_OUT    = 2,
    parameter int CNT_W    = 8,
    parameter int WIN_W    = 16,
    parameter int WINNER_W = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    spike_readout_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_pre = c_cnt_max - CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_DECIDE = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WIN_W-1:0]      r_win_len;
    logic [WIN_W-1:0]      r_win_cnt;
    logic [CNT_W-1:0]      r_cnt [N_OUT];
    logic [N_OUT-1:0]      r_sat;
    logic [WINNER_W-1:0]   r_winner;
    logic [WINNER_W-1:0]   w_best_idx;
    logic [CNT_W-1:0]      w_best_cnt;
    logic                  w_start_ok;
    logic                  w_win_done;
    logic                  w_busy;
    logic                  w_valid;

    assign w_start_ok = bus.start && (bus.win_len != '0);
    assign w_win_done = (r_win_cnt == (r_win_len - WIN_W'(1)));

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_COUNT;
            end
            S_COUNT: begin
                w_busy = 1'b1;
                if (w_win_done) w_next = S_DECIDE;
            end
            S_DECIDE: begin
                w_busy = 1'b1;
                w_next = S_REPORT;
            end
            S_REPORT: begin
                w_valid = 1'b1;
                if (bus.result_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on ties
    always_comb begin
        w_best_idx = '0;
        w_best_cnt = r_cnt[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (r_cnt[i] > w_best_cnt) begin
                w_best_cnt = r_cnt[i];
                w_best_idx = WINNER_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_len <= '0;
            r_win_cnt <= '0;
            r_sat     <= '0;
            r_winner  <= '0;
            for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_win_len <= bus.win_len;
                        r_win_cnt <= '0;
                        r_sat     <= '0;
                        for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
                    end
                end
                S_COUNT: begin
                    r_win_cnt <= r_win_cnt + WIN_W'(1);
                    for (int i = 0; i < N_OUT; i++) begin
                        if (bus.spike_in[i] && (r_cnt[i] != c_cnt_max)) begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            if (r_cnt[i] == c_cnt_pre) r_sat[i] <= 1'b1;
                        end
                    end
                end
                S_DECIDE: r_winner <= w_best_idx;
                default: ;
            endcase
        end
    end

`ifdef SPIKE_READOUT_MIN_COUNT_EN
    logic r_no_decision;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_no_decision <= 1'b0;
        end else if (r_state == S_IDLE && w_start_ok) begin
            r_no_decision <= 1'b0;
        end else if (r_state == S_DECIDE) begin
            r_no_decision <= (w_best_cnt < bus.min_count);
        end
    end

    assign bus.no_decision = r_no_decision;
`endif

    generate
        for (genvar g = 0; g < N_OUT; g++) begin : g_pack
            assign bus.count_out[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

    assign bus.busy         = w_busy;
    assign bus.result_valid = w_valid;
    assign bus.winner       = r_winner;
    assign bus.sat          = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_spike_readout.sv
//==============================================================================
// Module      : tb_spike_readout
// Description : Randomized self-checking bench; drives a default-width and a
//               4-bit-counter spike_readout in lockstep against a window model.
//               Honours SPIKE_READOUT_MIN_COUNT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spike_readout;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  spike;
    logic        start;
    logic [15:0] win_len;
    logic        ready;

    always #5 clk = ~clk;

    spike_readout_if #(.N_OUT(2), .CNT_W(8), .WIN_W(16), .WINNER_W(1)) ifa ();
    spike_readout_if #(.N_OUT(2), .CNT_W(4), .WIN_W(16), .WINNER_W(1)) ifb ();

    assign ifa.spike_in     = spike;
    assign ifa.start        = start;
    assign ifa.win_len      = win_len;
    assign ifa.result_ready = ready;
    assign ifb.spike_in     = spike;
    assign ifb.start        = start;
    assign ifb.win_len      = win_len;
    assign ifb.result_ready = ready;

`ifdef SPIKE_READOUT_MIN_COUNT_EN
    logic [7:0] mc;
    assign ifa.min_count = mc;
    assign ifb.min_count = mc[3:0];
`endif

    spike_readout #(.N_OUT(2), .CNT_W(8), .WIN_W(16), .WINNER_W(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    spike_readout #(.N_OUT(2), .CNT_W(4), .WIN_W(16), .WINNER_W(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  pat [64];
    logic [15:0] exp_cnt_a, exp_cnt_b;
    logic [1:0]  exp_sat_a, exp_sat_b;
    logic        exp_win_a, exp_win_b;
    logic        exp_nd_a,  exp_nd_b;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window outcome from the pattern: saturating sums, sat when the sum reaches
    // the ceiling, first index holding the maximum count wins.
    task automatic model(input int len, input int cw, input int min_cnt,
                         output logic [15:0] cnt_pk, output logic [1:0] sat_v,
                         output logic win, output logic nd);
        int maxv;
        int c [2];
        int best;
        maxv = (1 << cw) - 1;
        for (int i = 0; i < 2; i++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < len; k++) sum += int'(pat[k][i]);
            c[i]     = (sum > maxv) ? maxv : sum;
            sat_v[i] = (sum >= maxv);
        end
        best = 0;
        for (int i = 1; i < 2; i++) if (c[i] > c[best]) best = i;
        win    = best[0];
        cnt_pk = 16'(c[0]) | (16'(c[1]) << cw);
        nd     = (c[best] < min_cnt);
    endtask

    task automatic check_ctrl(input string ph, input logic exp_busy, input logic exp_valid);
        check_val({ph, ":a_busy"},  64'(ifa.busy),         64'(exp_busy));
        check_val({ph, ":a_valid"}, 64'(ifa.result_valid), 64'(exp_valid));
        check_val({ph, ":b_busy"},  64'(ifb.busy),         64'(exp_busy));
        check_val({ph, ":b_valid"}, 64'(ifb.result_valid), 64'(exp_valid));
    endtask

    task automatic check_data(input string ph);
        check_val({ph, ":a_count"},  64'(ifa.count_out), 64'(exp_cnt_a));
        check_val({ph, ":a_winner"}, 64'(ifa.winner),    64'(exp_win_a));
        check_val({ph, ":a_sat"},    64'(ifa.sat),       64'(exp_sat_a));
        check_val({ph, ":b_count"},  64'(ifb.count_out), 64'(exp_cnt_b));
        check_val({ph, ":b_winner"}, 64'(ifb.winner),    64'(exp_win_b));
        check_val({ph, ":b_sat"},    64'(ifb.sat),       64'(exp_sat_b));
`ifdef SPIKE_READOUT_MIN_COUNT_EN
        check_val({ph, ":a_nodec"},  64'(ifa.no_decision), 64'(exp_nd_a));
        check_val({ph, ":b_nodec"},  64'(ifb.no_decision), 64'(exp_nd_b));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge with both DUTs idle.
    // bp < 0 picks a random number of backpressure cycles.
    task automatic run_window(input string ph, input int len, input int bp);
        int mca, mcb, nbp;
        mca = 0;
        mcb = 0;
`ifdef SPIKE_READOUT_MIN_COUNT_EN
        mca = int'(mc);
        mcb = int'(mc[3:0]);
`endif
        model(len, 8, mca, exp_cnt_a, exp_sat_a, exp_win_a, exp_nd_a);
        model(len, 4, mcb, exp_cnt_b, exp_sat_b, exp_win_b, exp_nd_b);

        start   = 1'b1;
        win_len = 16'(len);
        tick();
        for (int k = 0; k < len; k++) begin
            spike   = pat[k];
            start   = 1'($urandom_range(0, 1));
            win_len = 16'($urandom_range(0, 65535));
            check_ctrl({ph, ":count"}, 1'b1, 1'b0);
            tick();
        end
        spike = 2'($urandom_range(0, 3));
        check_ctrl({ph, ":decide"}, 1'b1, 1'b0);
        tick();
        spike = 2'($urandom_range(0, 3));
        start = 1'b0;
        check_ctrl({ph, ":report"}, 1'b0, 1'b1);
        check_data({ph, ":report"});

        nbp = (bp < 0) ? $urandom_range(0, 6) : bp;
        for (int j = 0; j < nbp; j++) begin
            ready   = 1'b0;
            start   = (j % 3 == 1);
            win_len = 16'($urandom_range(1, 40));
            tick();
            check_ctrl({ph, ":hold"}, 1'b0, 1'b1);
            check_data({ph, ":hold"});
        end
        ready   = 1'b1;
        start   = 1'b1;
        win_len = 16'($urandom_range(1, 40));
        tick();
        ready = 1'b0;
        start = 1'b0;
        spike = 2'b00;
        check_ctrl({ph, ":accept"}, 1'b0, 1'b0);
        check_data({ph, ":idle"});
        tick();
        check_ctrl({ph, ":idle2"}, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        spike   = 2'b00;
        start   = 1'b0;
        win_len = '0;
        ready   = 1'b0;
`ifdef SPIKE_READOUT_MIN_COUNT_EN
        mc = '0;
`endif
        exp_cnt_a = '0; exp_cnt_b = '0;
        exp_sat_a = '0; exp_sat_b = '0;
        exp_win_a = '0; exp_win_b = '0;
        exp_nd_a  = '0; exp_nd_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_ctrl("reset", 1'b0, 1'b0);
        check_data("reset");
        rst_n = 1'b1;
        tick();

        // Line 0 every cycle, line 1 on four cycles
        for (int k = 0; k < 10; k++) pat[k] = {(k < 4), 1'b1};
        run_window("t1", 10, 0);

        // Tie resolves to index 0; optional threshold above the winning count
`ifdef SPIKE_READOUT_MIN_COUNT_EN
        mc = 8'd6;
`endif
        for (int k = 0; k < 8; k++) pat[k] = (k < 5) ? 2'b11 : 2'b00;
        run_window("t2", 8, 1);

        // Line 1 saturates the 4-bit counters
        for (int k = 0; k < 20; k++) pat[k] = 2'b10;
        run_window("t3", 20, 2);

        // Long backpressure, then a short window
        for (int k = 0; k < 10; k++) pat[k] = 2'($urandom_range(0, 3));
        run_window("t4", 10, 6);
        for (int k = 0; k < 3; k++) pat[k] = 2'($urandom_range(0, 3));
        run_window("t4b", 3, 0);

        // Zero-length window request is ignored
        start   = 1'b1;
        win_len = '0;
        tick();
        start = 1'b0;
        check_ctrl("t6_zero", 1'b0, 1'b0);
        check_data("t6_zero");
        tick();
        check_ctrl("t6_zero2", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a window
        start   = 1'b1;
        win_len = 16'd10;
        tick();
        start = 1'b0;
        spike = 2'b11;
        repeat (5) tick();
        rst_n = 1'b0;
        #2;
        exp_cnt_a = '0; exp_cnt_b = '0;
        exp_sat_a = '0; exp_sat_b = '0;
        exp_win_a = '0; exp_win_b = '0;
        exp_nd_a  = '0; exp_nd_b  = '0;
        check_ctrl("t5_rst", 1'b0, 1'b0);
        check_data("t5_rst");
        tick();
        rst_n = 1'b1;
        spike = 2'b00;
        tick();
        check_ctrl("t5_after", 1'b0, 1'b0);
        pat[0] = 2'b10;
        pat[1] = 2'b00;
        run_window("t5", 2, 0);

        // Random windows
        for (int w = 0; w < 15; w++) begin
            int len, p0, p1;
            len = $urandom_range(1, 40);
            p0  = $urandom_range(0, 100);
            p1  = $urandom_range(0, 100);
            for (int k = 0; k < len; k++)
                pat[k] = {($urandom_range(0, 99) < p1), ($urandom_range(0, 99) < p0)};
`ifdef SPIKE_READOUT_MIN_COUNT_EN
            mc = 8'($urandom_range(0, 30));
`endif
            run_window($sformatf("rnd%0d", w), len, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spike_readout.md
Name: spike_readout

Overview:
- Downstream readout stage for the output-neuron layer. Consumes one spike line per output neuron.
- Counts spikes per neuron over a programmable window of clock cycles, then reports a winner and the per-neuron counts.
- Results are held under a valid/ready handshake so a host or wrapper can sample the classification.

Parameters:
N_OUT, 2, number of output-neuron spike lines counted
CNT_W, 8, width of each per-neuron spike counter (saturating)
WIN_W, 16, width of the window-length input and internal cycle counter
WINNER_W, 1, width of winner index; must be >= max(1, clog2(N_OUT))

Ports:
clk  input  1  single system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
spike_in  input  N_OUT  one spike line per output neuron; sampled only in COUNT
start  input  1  single-cycle request to begin a window; honoured only in IDLE
win_len  input  WIN_W  window length in cycles; latched when start is accepted
result_ready  input  1  consumer accepts the result when high while result_valid is high
busy  output  1  high in COUNT and DECIDE
result_valid  output  1  high in REPORT only
count_out  output  N_OUT*CNT_W  packed counts; neuron i in bits [i*CNT_W +: CNT_W]
winner  output  WINNER_W  index of the neuron with the highest count
sat  output  N_OUT  per-neuron flag: counter reached all-ones during the window

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, result_valid, count_out, winner, sat all 0.
  - Internal window counter cleared.
  - Applies mid-window and mid-REPORT alike; no result is produced for an interrupted window.
- IDLE:
  - start=1 with win_len!=0: at that edge, latch win_len, clear counts and sat, go to COUNT.
  - start=1 with win_len==0: ignored; stay in IDLE.
  - count_out and winner keep the last reported values.
- COUNT:
  - On each edge, for each i with spike_in[i]=1, count_i increments by 1.
  - At 2^CNT_W-1 the counter holds and sat[i] is set; sat stays set until the next accepted start.
  - The window counter increments every edge. On the edge that samples the win_len-th cycle, go to DECIDE.
  - spike_in is therefore sampled on exactly win_len edges, edges 1..win_len after the start edge.
  - start is ignored.
- DECIDE (one cycle):
  - At the edge, register winner = argmax of the counts; ties resolve to the lowest index.
  - Go to REPORT.
  - spike_in is not sampled.
- REPORT:
  - result_valid=1; count_out, winner and sat are stable.
  - On an edge with result_ready=1, go to IDLE; result_valid drops after that edge.
  - start is ignored in REPORT, including on the acceptance cycle.
- Latency: result_valid first high after edge win_len+1, counted from the start edge (edge 0).
- result_ready is don't-care outside REPORT.
- busy = (state==COUNT or DECIDE).

Optional Feature:
Macro SPIKE_READOUT_MIN_COUNT_EN.
- Defined:
  - Adds input min_count (CNT_W bits) and output no_decision (1 bit, reset 0).
  - In DECIDE, no_decision is set when the winning count < min_count; winner still holds the argmax index.
  - no_decision is cleared on the next accepted start.
- Undefined:
  - No extra ports.
  - Every window yields a decision; behaviour is otherwise identical.

Test Plan:
1. Defaults, win_len=10. spike_in[0] high all 10 sampled cycles, spike_in[1] high on 4 of them. Expect counts {4,10}, winner=0, sat=0, result_valid rising after edge 11, busy high edges 1..11.
2. Tie: win_len=8, both lines high for 5 sampled cycles. Expect counts 5/5, winner=0.
3. Saturation: CNT_W=4, win_len=20, spike_in[1] constant high, spike_in[0] low. Expect count1=15, sat=2'b10, count0=0, winner=1.
4. Backpressure: hold result_ready=0 for 6 cycles in REPORT and pulse start twice. Expect outputs stable and starts ignored. Raise result_ready: IDLE after one edge, result_valid=0. Then a new start with win_len=3 runs a normal window.
5. Reset: assert reset low mid-COUNT (edge 5 of 10). Expect all outputs 0 immediately and no result_valid. Release, start with win_len=2, one spike on line 1: counts {1,0}, winner=1.
6. win_len=0 with start: expect busy stays 0 and no result. With SPIKE_READOUT_MIN_COUNT_EN, min_count=6 and a winning count of 5: expect no_decision=1, winner=argmax index.
